// File: rtl/ofs_plat_avalon_burst_credit_arb_if.sv
// Request/slave-side bundle of the burst credit arbiter: per-port heads, the
// forwarded beat, and the completion return from the port-index tracker.
interface ofs_plat_avalon_burst_credit_arb_if #(
  parameter int NUM_PORTS       = 2,
  parameter int BURST_CNT_WIDTH = 7
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]                 req_valid;
  logic [NUM_PORTS*BURST_CNT_WIDTH-1:0] req_burstcount;
  logic [NUM_PORTS-1:0]                 req_ready;
  logic                                 slave_waitrequest;
  logic                                 slave_valid;
  logic [IDX_W-1:0]                     grant_idx;
  logic                                 grant_sop;
  logic                                 rsp_done;
  logic [IDX_W-1:0]                     rsp_port_idx;

  // Arbiter view.
  modport slave (
    input  req_valid, req_burstcount, slave_waitrequest, rsp_done, rsp_port_idx,
    output req_ready, slave_valid, grant_idx, grant_sop
  );

  // Requester / environment view.
  modport master (
    output req_valid, req_burstcount, slave_waitrequest, rsp_done, rsp_port_idx,
    input  req_ready, slave_valid, grant_idx, grant_sop
  );
endinterface

// File: rtl/ofs_plat_avalon_burst_credit_arb.sv
// Burst-aware round-robin arbiter with per-port outstanding-burst credits.
// Define OFS_PLAT_AVALON_BURST_ARB_STATS_EN to add per-port SOP/starvation counters.
module ofs_plat_avalon_burst_credit_arb #(
  parameter int NUM_PORTS       = 2,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int MAX_OUTSTANDING = 16,
  parameter int HOLD_FOR_BURST  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ofs_plat_avalon_burst_credit_arb_if.slave bus,
  output logic [NUM_PORTS-1:0]   credit_avail,
  output logic                   idle
`ifdef OFS_PLAT_AVALON_BURST_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0] stat_sop_count,
  output logic [NUM_PORTS*32-1:0] stat_starve_cycles
`endif
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CRD_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           rr_q, rr_d;
  logic [IDX_W-1:0]           locked_q, locked_d;
  logic [BURST_CNT_WIDTH-1:0] beats_left_q, beats_left_d;
  logic [CRD_W-1:0]           credit_q [NUM_PORTS];
  logic [CRD_W-1:0]           credit_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]       credit_avail_q, credit_avail_d;

  logic [NUM_PORTS-1:0]       eligible;
  logic [NUM_PORTS-1:0]       crd_dec, crd_inc;
  logic [IDX_W-1:0]           winner;
  logic                       win_found;
  logic [BURST_CNT_WIDTH-1:0] win_bc;
  logic                       sop_grant;
  logic                       fwd;
  logic [NUM_PORTS-1:0]       ready;
  logic [IDX_W-1:0]           grant_idx_c;
  logic                       all_full;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      eligible[p] = bus.req_valid[p] && (credit_q[p] != '0);
    end
  end

  // First eligible port at or after the RR pointer, wrapping at NUM_PORTS.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    winner    = '0;
    win_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = IDX_W'(cand);
      if (!win_found && eligible[cand_idx]) begin
        win_found = 1'b1;
        winner    = cand_idx;
      end
    end
  end

  assign win_bc = bus.req_burstcount[int'(winner)*BURST_CNT_WIDTH +: BURST_CNT_WIDTH];

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    locked_d     = locked_q;
    beats_left_d = beats_left_q;
    ready        = '0;
    fwd          = 1'b0;
    sop_grant    = 1'b0;
    grant_idx_c  = '0;
    case (state_q)
      ARB: begin
        if (!bus.slave_waitrequest && win_found) begin
          sop_grant      = 1'b1;
          fwd            = 1'b1;
          ready[winner]  = 1'b1;
          grant_idx_c    = winner;
          rr_d           = (int'(winner) == NUM_PORTS - 1) ? '0 : winner + IDX_W'(1);
          // burstcount 0 falls through here and behaves as a single beat
          if ((HOLD_FOR_BURST != 0) && (win_bc > BURST_CNT_WIDTH'(1))) begin
            locked_d     = winner;
            beats_left_d = win_bc - BURST_CNT_WIDTH'(1);
            state_d      = BURST;
          end
        end
      end
      BURST: begin
        grant_idx_c = locked_q;
        if (!bus.slave_waitrequest && bus.req_valid[locked_q]) begin
          fwd             = 1'b1;
          ready[locked_q] = 1'b1;
          beats_left_d    = beats_left_q - BURST_CNT_WIDTH'(1);
          if (beats_left_q == BURST_CNT_WIDTH'(1)) state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // A grant and a completion on the same port in one cycle cancel out.
  always_comb begin
    all_full = 1'b1;
    for (int p = 0; p < NUM_PORTS; p++) begin
      crd_dec[p] = sop_grant && (winner == IDX_W'(p));
      crd_inc[p] = bus.rsp_done && (bus.rsp_port_idx == IDX_W'(p));
      credit_d[p] = credit_q[p];
      if (crd_dec[p] && !crd_inc[p]) begin
        credit_d[p] = credit_q[p] - CRD_W'(1);
      end else if (crd_inc[p] && !crd_dec[p] && (credit_q[p] != CRD_W'(MAX_OUTSTANDING))) begin
        credit_d[p] = credit_q[p] + CRD_W'(1);
      end
      credit_avail_d[p] = (credit_d[p] != '0);
      if (credit_q[p] != CRD_W'(MAX_OUTSTANDING)) all_full = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ARB;
      rr_q           <= '0;
      locked_q       <= '0;
      beats_left_q   <= '0;
      credit_avail_q <= '1;
      for (int p = 0; p < NUM_PORTS; p++) credit_q[p] <= CRD_W'(MAX_OUTSTANDING);
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      locked_q       <= locked_d;
      beats_left_q   <= beats_left_d;
      credit_avail_q <= credit_avail_d;
      for (int p = 0; p < NUM_PORTS; p++) credit_q[p] <= credit_d[p];
    end
  end

  // Handshake outputs are combinational, so gate them while reset is held.
  assign bus.req_ready   = reset_n ? ready : '0;
  assign bus.slave_valid = reset_n & fwd;
  assign bus.grant_sop   = reset_n & sop_grant;
  assign bus.grant_idx   = grant_idx_c;
  assign credit_avail    = credit_avail_q;
  assign idle            = (state_q == ARB) && all_full && (bus.req_valid == '0);

`ifdef OFS_PLAT_AVALON_BURST_ARB_STATS_EN
  logic [31:0] sop_cnt_q    [NUM_PORTS];
  logic [31:0] starve_cnt_q [NUM_PORTS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        sop_cnt_q[p]    <= '0;
        starve_cnt_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (crd_dec[p]) sop_cnt_q[p] <= sop_cnt_q[p] + 32'd1;
        if ((state_q == ARB) && !bus.slave_waitrequest && eligible[p] && !crd_dec[p]) begin
          starve_cnt_q[p] <= starve_cnt_q[p] + 32'd1;
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_stat
    assign stat_sop_count[p*32 +: 32]     = sop_cnt_q[p];
    assign stat_starve_cycles[p*32 +: 32] = starve_cnt_q[p];
  end
`endif
endmodule

// File: tb/tb_ofs_plat_avalon_burst_credit_arb.sv
// Directed bench: reset, RR fairness, burst lock, credit limit/saturation,
// reset mid-burst and, with OFS_PLAT_AVALON_BURST_ARB_STATS_EN, the counters.
module tb_ofs_plat_avalon_burst_credit_arb;
  logic clk;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [1:0] ca_a, ca_b;
  logic       idle_a, idle_b;

  // DUT A: write mode, two credits per port. DUT B: read mode, default credits.
  ofs_plat_avalon_burst_credit_arb_if #(.NUM_PORTS(2), .BURST_CNT_WIDTH(7)) ifa ();
  ofs_plat_avalon_burst_credit_arb_if #(.NUM_PORTS(2), .BURST_CNT_WIDTH(7)) ifb ();

`ifdef OFS_PLAT_AVALON_BURST_ARB_STATS_EN
  logic [63:0] sop_a, stv_a, sop_b, stv_b;
  logic [95:0] sop_c, stv_c;
  logic [2:0]  ca_c;
  logic        idle_c;
  ofs_plat_avalon_burst_credit_arb_if #(.NUM_PORTS(3), .BURST_CNT_WIDTH(7)) ifc ();
  ofs_plat_avalon_burst_credit_arb #(.NUM_PORTS(3), .BURST_CNT_WIDTH(7),
    .MAX_OUTSTANDING(16), .HOLD_FOR_BURST(0)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .bus(ifc), .credit_avail(ca_c), .idle(idle_c),
    .stat_sop_count(sop_c), .stat_starve_cycles(stv_c));
`endif

  ofs_plat_avalon_burst_credit_arb #(.NUM_PORTS(2), .BURST_CNT_WIDTH(7),
    .MAX_OUTSTANDING(2), .HOLD_FOR_BURST(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa), .credit_avail(ca_a), .idle(idle_a)
`ifdef OFS_PLAT_AVALON_BURST_ARB_STATS_EN
    , .stat_sop_count(sop_a), .stat_starve_cycles(stv_a)
`endif
  );

  ofs_plat_avalon_burst_credit_arb #(.NUM_PORTS(2), .BURST_CNT_WIDTH(7),
    .MAX_OUTSTANDING(16), .HOLD_FOR_BURST(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb), .credit_avail(ca_b), .idle(idle_b)
`ifdef OFS_PLAT_AVALON_BURST_ARB_STATS_EN
    , .stat_sop_count(sop_b), .stat_starve_cycles(stv_b)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle on DUT A: drive at the falling edge, check combinational and
  // registered outputs 1 ns later. eca/eidle < 0 skip that check.
  task automatic va(input int rst, input int wr, input int vld, input int bc0, input int bc1,
                    input int rsp, input int ridx, input int esv, input int eidx,
                    input int esop, input int eca, input int eidle);
    logic [1:0] er;
    @(negedge clk);
    reset_n                  = rst[0];
    ifa.slave_waitrequest    = wr[0];
    ifa.req_valid            = vld[1:0];
    ifa.req_burstcount       = {bc1[6:0], bc0[6:0]};
    ifa.rsp_done             = rsp[0];
    ifa.rsp_port_idx         = ridx[0];
    #1;
    er = (esv != 0) ? 2'(1 << eidx) : 2'd0;
    chk_eq("a_slave_valid", 64'(ifa.slave_valid), 64'(esv));
    chk_eq("a_req_ready", 64'(ifa.req_ready), 64'(er));
    chk_eq("a_grant_sop", 64'(ifa.grant_sop), 64'(esop));
    if (esv != 0) chk_eq("a_grant_idx", 64'(ifa.grant_idx), 64'(eidx));
    if (eca >= 0) chk_eq("a_credit_avail", 64'(ca_a), 64'(eca));
    if (eidle >= 0) chk_eq("a_idle", 64'(idle_a), 64'(eidle));
  endtask

  logic pv1, pv2, pi1, pi2;

  initial begin
    reset_n = 1'b0;
    ifa.req_valid = '0; ifa.req_burstcount = '0; ifa.slave_waitrequest = 1'b0;
    ifa.rsp_done = 1'b0; ifa.rsp_port_idx = '0;
    ifb.req_valid = '0; ifb.req_burstcount = {7'd1, 7'd1}; ifb.slave_waitrequest = 1'b0;
    ifb.rsp_done = 1'b0; ifb.rsp_port_idx = '0;
`ifdef OFS_PLAT_AVALON_BURST_ARB_STATS_EN
    ifc.req_valid = '0; ifc.req_burstcount = {7'd1, 7'd1, 7'd1}; ifc.slave_waitrequest = 1'b0;
    ifc.rsp_done = 1'b0; ifc.rsp_port_idx = '0;
`endif
    pv1 = 1'b0; pv2 = 1'b0; pi1 = 1'b0; pi2 = 1'b0;

    // Reset state, with requests present and absent.
    va(0,0,3,1,1,0,0, 0,0,0, 3,-1);
    va(0,0,0,1,1,0,0, 0,0,0, 3, 1);
    va(1,0,0,1,1,0,0, 0,0,0, 3, 1);

    // Fairness on DUT B: completions return two cycles after each grant.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ifb.req_valid    = 2'b11;
      ifb.rsp_done     = pv2;
      ifb.rsp_port_idx = pi2;
      #1;
      chk_eq("b_slave_valid", 64'(ifb.slave_valid), 64'd1);
      chk_eq("b_grant_idx", 64'(ifb.grant_idx), 64'(i % 2));
      chk_eq("b_grant_sop", 64'(ifb.grant_sop), 64'd1);
      pv2 = pv1; pi2 = pi1;
      pv1 = ifb.slave_valid; pi1 = ifb.grant_idx;
    end
    @(negedge clk);
    ifb.req_valid = '0; ifb.rsp_done = 1'b0;

    // Burst lock: port 0 x4 with a 3-cycle stall, then port 1.
    va(1,0,3,4,1,0,0, 1,0,1,-1,-1);
    va(1,0,3,4,1,0,0, 1,0,0,-1,-1);
    for (int i = 0; i < 3; i++) va(1,1,3,4,1,0,0, 0,0,0,-1,-1);
    va(1,0,3,4,1,0,0, 1,0,0,-1,-1);
    va(1,0,3,4,1,0,0, 1,0,0,-1,-1);
    va(1,0,3,4,1,0,0, 1,1,1,-1,-1);
    va(1,0,0,1,1,0,0, 0,0,0, 3, 0);
    // Return both credits.
    va(1,0,0,1,1,1,0, 0,0,0,-1,-1);
    va(1,0,0,1,1,1,1, 0,0,0,-1,-1);

    // Credit limit on port 0, port 1 still served, one completion re-enables.
    va(1,0,1,1,1,0,0, 1,0,1,-1,-1);
    va(1,0,1,1,1,0,0, 1,0,1,-1,-1);
    va(1,0,1,1,1,0,0, 0,0,0, 2,-1);
    va(1,0,3,1,1,0,0, 1,1,1,-1,-1);
    va(1,0,1,1,1,1,0, 0,0,0, 2,-1);
    va(1,0,1,1,1,0,0, 1,0,1,-1,-1);

    // Grant and completion on port 0 in the same cycle leave credit at 1.
    va(1,0,0,1,1,1,0, 0,0,0, 2,-1);
    va(1,0,1,1,1,1,0, 1,0,1, 3,-1);
    va(1,0,1,1,1,0,0, 1,0,1, 3,-1);
    va(1,0,1,1,1,0,0, 0,0,0, 2,-1);

    // Spurious completion on port 1 at full credit saturates at 2.
    va(1,0,0,1,1,1,1, 0,0,0, 2,-1);
    va(1,0,0,1,1,1,1, 0,0,0, 2,-1);
    va(1,0,2,1,1,0,0, 1,1,1, 2,-1);
    va(1,0,2,1,1,0,0, 1,1,1, 2,-1);
    va(1,0,2,1,1,0,0, 0,0,0, 0,-1);

    // Reset after 2 of 8 beats, then first grant goes to port 0.
    va(1,0,0,1,1,1,0, 0,0,0, 0,-1);
    va(1,0,1,8,1,0,0, 1,0,1, 1,-1);
    va(1,0,1,8,1,0,0, 1,0,0, 0,-1);
    va(0,0,1,8,1,0,0, 0,0,0, 3,-1);
    va(0,0,0,1,1,0,0, 0,0,0, 3, 1);
    va(1,0,0,1,1,0,0, 0,0,0, 3, 1);
    va(1,0,3,1,1,0,0, 1,0,1, 3, 0);
    va(1,0,3,1,1,0,0, 1,1,1, 3,-1);
    va(1,0,0,1,1,0,0, 0,0,0,-1,-1);

`ifdef OFS_PLAT_AVALON_BURST_ARB_STATS_EN
    // Three ports always valid: grants 0,1,2,0,1,2,0.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ifc.req_valid = 3'b111;
      #1;
      chk_eq("c_grant_idx", 64'(ifc.grant_idx), 64'(i % 3));
    end
    @(negedge clk);
    ifc.req_valid = '0;
    #1;
    chk_eq("c_sop0", 64'(sop_c[31:0]), 64'd3);
    chk_eq("c_sop1", 64'(sop_c[63:32]), 64'd2);
    chk_eq("c_sop2", 64'(sop_c[95:64]), 64'd2);
    chk_eq("c_starve0", 64'(stv_c[31:0]), 64'd4);
    chk_eq("c_starve1", 64'(stv_c[63:32]), 64'd5);
    chk_eq("c_starve2", 64'(stv_c[95:64]), 64'd5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ofs_plat_avalon_burst_credit_arb.md
Name: ofs_plat_avalon_burst_credit_arb

Overview:
- Burst-aware round-robin arbiter that lets NUM_PORTS requesters share one Avalon burst channel (read or write) feeding a single slave.
- In write mode, the grant is held for every beat of a burst. Per-port credit counters cap the number of outstanding bursts, so one port cannot fill the shared response tracker.
- Sits between the per-port request FIFOs and the shared slave register stage. The external port-index tracker FIFO returns completions through rsp_done/rsp_port_idx.

Parameters:
- NUM_PORTS, 2, number of requesters (>=2).
- BURST_CNT_WIDTH, 7, width of the Avalon burstcount field.
- MAX_OUTSTANDING, 16, maximum bursts in flight per port (>=1).
- HOLD_FOR_BURST, 1, 1 = write mode (grant locked for burstcount beats); 0 = read mode (one beat per request).
- Derived: IDX_W = $clog2(NUM_PORTS); CRD_W = $clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  Single clock; all logic is on its rising edge.
- reset_n  in  1  Reset, asynchronous assert, active-low.
- req_valid  in  NUM_PORTS  Per-port beat available; bit p is the head of port p's FIFO.
- req_burstcount  in  NUM_PORTS*BURST_CNT_WIDTH  Per-port burstcount of the head beat; port p occupies slice [p*BURST_CNT_WIDTH +: BURST_CNT_WIDTH].
- req_ready  out  NUM_PORTS  Beat consumed from port p this cycle (one-hot or zero).
- slave_waitrequest  in  1  Shared channel stall.
- slave_valid  out  1  A beat is forwarded to the slave this cycle.
- grant_idx  out  IDX_W  Source port of the forwarded beat; meaningful only when slave_valid=1.
- grant_sop  out  1  The forwarded beat is the first beat of a burst.
- rsp_done  in  1  One burst has fully completed at the slave.
- rsp_port_idx  in  IDX_W  Port that owns the rsp_done completion.
- credit_avail  out  NUM_PORTS  Port p has credit > 0 (registered).
- idle  out  1  In ARB state, no credits consumed, no req_valid asserted.

Behaviour:
- Reset values (asynchronous, while reset_n=0):
  - state=ARB.
  - Every credit = MAX_OUTSTANDING.
  - RR pointer gives port 0 highest priority.
  - beats_left=0.
  - req_ready=0, slave_valid=0, grant_sop=0, credit_avail=all 1s, idle=1.
  - req_ready and slave_valid are forced 0 while reset_n=0.
- Latency: request to grant is combinational (0 cycles). Credit, pointer and state updates are visible the next cycle.
- Eligibility: eligible[p] = req_valid[p] & (credit[p] != 0).
- ARB state:
  - If !slave_waitrequest and eligible != 0, the winner is the first eligible port at or after the RR pointer, wrapping from NUM_PORTS-1 to 0.
  - On a win: req_ready[winner]=1, slave_valid=1, grant_sop=1, grant_idx=winner, credit[winner] decrements, and the RR pointer becomes winner+1 (mod NUM_PORTS).
  - If HOLD_FOR_BURST=1 and the winner's burstcount > 1: lock locked_idx=winner, set beats_left = burstcount-1, go to BURST.
  - Otherwise stay in ARB.
  - If slave_waitrequest=1: no grant, and the pointer and credits do not change.
- BURST state (write mode only):
  - Only locked_idx is served; arbitration is frozen.
  - req_ready[locked_idx] = !slave_waitrequest & req_valid[locked_idx].
  - slave_valid equals that same term; grant_sop=0.
  - Credits are not checked or consumed on continuation beats.
  - Each accepted beat decrements beats_left. Accepting the beat when beats_left==1 returns to ARB, and the next cycle may grant a new SOP.
  - A bubble (req_valid low) holds the state; other ports are not served.
- burstcount 0 is treated as 1.
- Credits:
  - A SOP grant on port p decrements credit[p]. rsp_done with rsp_port_idx=p increments it.
  - If both happen on the same port in the same cycle, the credit is unchanged.
  - An increment while credit==MAX_OUTSTANDING saturates (the spurious completion is ignored).
  - An rsp_port_idx >= NUM_PORTS is ignored.
- The RR pointer advances only on SOP grants.
- Reset mid-burst: the async clear aborts the burst. Upstream FIFOs are reset together, so no partial-burst recovery is performed.

Optional Feature:
- Macro: OFS_PLAT_AVALON_BURST_ARB_STATS_EN.
- When defined, two extra output ports are added:
  - stat_sop_count (NUM_PORTS*32): per-port count of SOP grants.
  - stat_starve_cycles (NUM_PORTS*32): per-port count of cycles where eligible[p]=1 in ARB, slave_waitrequest=0, and p did not win.
- Both counters wrap at 2^32 and clear asynchronously on reset.
- When not defined, the ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
- Fairness: NUM_PORTS=2, HOLD=0, both ports valid continuously, waitrequest=0, rsp_done returned 2 cycles after each grant → grant_idx sequence 0,1,0,1,...; every beat has grant_sop=1.
- Burst lock: HOLD=1; port 0 burstcount=4 and port 1 burstcount=1, both valid → beats 0,0,0,0 then 1. Waitrequest held for 3 cycles mid-burst → no beat forwarded and beats_left unchanged during the stall.
- Credit limit: MAX_OUTSTANDING=2, no rsp_done, port 0 always valid → exactly 2 SOP grants, credit_avail[0]=0, port 1 alone served afterwards. One rsp_done with idx 0 → port 0 granted again on the following cycle.
- Simultaneous events: port 0 credit=1, SOP grant to port 0 and rsp_done idx 0 in the same cycle → credit stays 1. rsp_done for port 1 while its credit=MAX → credit stays MAX.
- Reset mid-burst: assert reset_n=0 after 2 of 8 beats → same cycle req_ready=0 and slave_valid=0. After release: state ARB, credits=MAX, idle=1, and the first grant goes to port 0.
- Stats (macro on): 3 ports, port 2 blocked by port 0 for 5 cycles → stat_starve_cycles[2]=5, and stat_sop_count matches the observed SOP grants.
